// File: rtl/ysyx_22041752_div_ctrl_pkg.sv
// Shared encodings for the divider sequencing controller: op codes, FSM states,
// and the register-file data width that sets the operand size.
package ysyx_22041752_div_ctrl_pkg;

    localparam int RF_DATA_WD = 64;

    localparam logic [1:0] YSYX_22041752_DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] YSYX_22041752_DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] YSYX_22041752_DIV_OP_REM  = 2'b10;
    localparam logic [1:0] YSYX_22041752_DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == YSYX_22041752_DIV_OP_DIV) || (op == YSYX_22041752_DIV_OP_REM);
    endfunction

    function automatic logic op_sel_rem(input logic [1:0] op);
        return (op == YSYX_22041752_DIV_OP_REM) || (op == YSYX_22041752_DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/ysyx_22041752_div_ctrl.sv
// Sequences one RV64M divide/remainder through an external iterative divider.
// Optional one-entry result cache: YSYX_22041752_DIV_CACHE_EN.
// state | meaning:  IDLE | waiting for a request;  BUSY | divider running;  DONE | result held for consumer
module ysyx_22041752_div_ctrl
    import ysyx_22041752_div_ctrl_pkg::*;
#(
    parameter int DATA_WD = RF_DATA_WD
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_flush,
    input  logic               i_req_valid,
    output logic               o_req_ready,
    input  logic [1:0]         i_req_op,
    input  logic               i_req_word,
    input  logic [DATA_WD-1:0] i_req_src1,
    input  logic [DATA_WD-1:0] i_req_src2,
    output logic               o_resp_valid,
    input  logic               i_resp_ready,
    output logic [DATA_WD-1:0] o_resp_result,
    output logic               o_div_valid,
    output logic               o_div_signed,
    output logic [DATA_WD-1:0] o_div_dividend,
    output logic [DATA_WD-1:0] o_div_divisor,
    input  logic               i_div_out_valid,
    input  logic [DATA_WD-1:0] i_div_quotient,
    input  logic [DATA_WD-1:0] i_div_remainder
);

    function automatic logic [DATA_WD-1:0] ext_operand(input logic [DATA_WD-1:0] src,
                                                       input logic word, input logic sgn);
        if (!word) return src;
        return {{(DATA_WD-32){sgn & src[31]}}, src[31:0]};
    endfunction

    function automatic logic [DATA_WD-1:0] ext_result(input logic [DATA_WD-1:0] val,
                                                      input logic word);
        if (!word) return val;
        return {{(DATA_WD-32){val[31]}}, val[31:0]};
    endfunction

    div_state_e         r_state;
    div_state_e         w_next_state;
    logic               r_signed;
    logic               r_sel_rem;
    logic               r_word;
    logic [DATA_WD-1:0] r_dividend;
    logic [DATA_WD-1:0] r_divisor;
    logic [DATA_WD-1:0] r_result;

    logic               w_req_signed;
    logic [DATA_WD-1:0] w_ext_src1;
    logic [DATA_WD-1:0] w_ext_src2;
    logic               w_accept;
    logic               w_complete;
    logic               w_hit;

    assign w_req_signed = op_is_signed(i_req_op);
    assign w_ext_src1   = ext_operand(i_req_src1, i_req_word, w_req_signed);
    assign w_ext_src2   = ext_operand(i_req_src2, i_req_word, w_req_signed);
    assign w_accept     = i_req_valid && o_req_ready && !i_flush;
    // A result landing in a flush cycle is dropped, so it must not update anything.
    assign w_complete   = (r_state == ST_BUSY) && i_div_out_valid && !i_flush;

`ifdef YSYX_22041752_DIV_CACHE_EN
    logic               r_c_valid;
    logic               r_c_signed;
    logic [DATA_WD-1:0] r_c_dividend;
    logic [DATA_WD-1:0] r_c_divisor;
    logic [DATA_WD-1:0] r_c_quot;
    logic [DATA_WD-1:0] r_c_rem;
    logic [DATA_WD-1:0] w_hit_val;

    assign w_hit = w_accept && r_c_valid && (r_c_signed == w_req_signed)
                && (r_c_dividend == w_ext_src1) && (r_c_divisor == w_ext_src2);
    assign w_hit_val = ext_result(op_sel_rem(i_req_op) ? r_c_rem : r_c_quot, i_req_word);

    // Survives flush on purpose: the entry describes a finished divide, not pipeline state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_c_valid    <= 1'b0;
            r_c_signed   <= 1'b0;
            r_c_dividend <= '0;
            r_c_divisor  <= '0;
            r_c_quot     <= '0;
            r_c_rem      <= '0;
        end else if (w_complete) begin
            r_c_valid    <= 1'b1;
            r_c_signed   <= r_signed;
            r_c_dividend <= r_dividend;
            r_c_divisor  <= r_divisor;
            r_c_quot     <= i_div_quotient;
            r_c_rem      <= i_div_remainder;
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_next_state = w_hit ? ST_DONE : ST_BUSY;
            ST_BUSY: if (w_complete) w_next_state = ST_DONE;
            ST_DONE: begin
                if (i_resp_ready) begin
                    if (w_accept) w_next_state = w_hit ? ST_DONE : ST_BUSY;
                    else          w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        if (i_flush) w_next_state = ST_IDLE;
    end

    always_comb begin
        o_req_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && i_resp_ready);
        o_div_valid  = (r_state == ST_BUSY) && !i_flush;
        o_resp_valid = (r_state == ST_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_signed   <= 1'b0;
            r_sel_rem  <= 1'b0;
            r_word     <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_result   <= '0;
        end else begin
            if (w_accept) begin
                r_signed   <= w_req_signed;
                r_sel_rem  <= op_sel_rem(i_req_op);
                r_word     <= i_req_word;
                r_dividend <= w_ext_src1;
                r_divisor  <= w_ext_src2;
            end
            if (w_complete)
                r_result <= ext_result(r_sel_rem ? i_div_remainder : i_div_quotient, r_word);
`ifdef YSYX_22041752_DIV_CACHE_EN
            if (w_hit)
                r_result <= w_hit_val;
`endif
        end
    end

    assign o_div_signed   = r_signed;
    assign o_div_dividend = r_dividend;
    assign o_div_divisor  = r_divisor;
    assign o_resp_result  = r_result;

endmodule

// File: tb/tb_ysyx_22041752_div_ctrl.sv
// Directed bench for the divider controller; plays the role of the iterative divider.
module tb_ysyx_22041752_div_ctrl;

`ifdef YSYX_22041752_DIV_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif
    localparam int HIT_LAT = CACHE_ON ? 1 : 67;

    logic        clk = 1'b0;
    logic        reset, flush, req_valid, req_ready, req_word;
    logic [1:0]  req_op;
    logic [63:0] req_src1, req_src2;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_result;
    logic        div_valid, div_signed, div_out_valid;
    logic [63:0] div_dividend, div_divisor, div_quotient, div_remainder;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_22041752_div_ctrl dut (
        .i_clk(clk), .i_reset(reset), .i_flush(flush),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_op(req_op), .i_req_word(req_word),
        .i_req_src1(req_src1), .i_req_src2(req_src2),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_result(resp_result),
        .o_div_valid(div_valid), .o_div_signed(div_signed),
        .o_div_dividend(div_dividend), .o_div_divisor(div_divisor),
        .i_div_out_valid(div_out_valid),
        .i_div_quotient(div_quotient), .i_div_remainder(div_remainder)
    );

    // Divider model: 66 cycles normally, 1 cycle for divisor 0 or signed divisor -1.
    int  dcnt;
    logic special;
    logic signed [63:0] sd, ss;
    always @(posedge clk) begin
        if (reset || !div_valid || div_out_valid) dcnt <= 0;
        else                                      dcnt <= dcnt + 1;
    end
    always_comb begin
        sd = div_dividend;
        ss = div_divisor;
        special = (div_divisor == 64'd0) || (div_signed && div_divisor == '1);
        div_out_valid = div_valid && (dcnt == (special ? 0 : 65));
        if (div_divisor == 64'd0) begin
            div_quotient  = '1;
            div_remainder = div_dividend;
        end else if (div_signed && div_divisor == '1) begin
            div_quotient  = -div_dividend;
            div_remainder = 64'd0;
        end else if (div_signed) begin
            div_quotient  = sd / ss;
            div_remainder = sd % ss;
        end else begin
            div_quotient  = div_dividend / div_divisor;
            div_remainder = div_dividend % div_divisor;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a, b,
                          output logic [63:0] res, output int lat,
                          output logic [63:0] dvd, output logic seen);
        req_op = op; req_word = w; req_src1 = a; req_src2 = b;
        req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; dvd = div_dividend; seen = 1'b0;
        while (!resp_valid && lat < 200) begin
            seen = seen | div_valid;
            @(posedge clk); #1;
            lat++;
        end
        res = resp_result;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        word;
        logic [63:0] s1;
        logic [63:0] s2;
        logic [63:0] exp_res;
        int          exp_lat;
        logic [63:0] exp_dvd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res, dvd;
        int          lat, hits;
        logic        seen;

        vecs[0]  = '{2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 67, 64'd100};
        vecs[1]  = '{2'b11, 1'b0, 64'd100, 64'd7, 64'd2, HIT_LAT, 64'd100};
        vecs[2]  = '{2'b00, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67, 64'hFFFF_FFFF_FFFF_FFF9};
        vecs[3]  = '{2'b10, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, HIT_LAT, 64'hFFFF_FFFF_FFFF_FFF9};
        vecs[4]  = '{2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                     64'hFFFF_FFFF_8000_0000, 2, 64'hFFFF_FFFF_8000_0000};
        vecs[5]  = '{2'b11, 1'b1, 64'd5, 64'd0, 64'd5, 2, 64'd5};
        vecs[6]  = '{2'b01, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 64'h1234};
        vecs[7]  = '{2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0001_0000_0002,
                     64'h0000_0000_7FFF_FFF8, 67, 64'h0000_0000_FFFF_FFF0};
        vecs[8]  = '{2'b10, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2,
                     64'hFFFF_FFFF_FFFF_FFFF, 67, 64'hFFFF_FFFF_FFFF_FFF9};
        vecs[9]  = '{2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, 2, 64'h8000_0000_0000_0000};
        vecs[10] = '{2'b00, 1'b0, 64'd1000, 64'd33, 64'd30, 67, 64'd1000};
        vecs[11] = '{2'b10, 1'b0, 64'd1000, 64'd33, 64'd10, HIT_LAT, 64'd1000};

        reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = 2'b00; req_word = 1'b0; req_src1 = '0; req_src2 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_result", resp_result, 64'd0);
        check("rst_div_valid", 64'(div_valid), 64'd0);
        check("rst_dividend", div_dividend, 64'd0);
        check("rst_divisor", div_divisor, 64'd0);
        check("rst_signed", 64'(div_signed), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].word, vecs[i].s1, vecs[i].s2, res, lat, dvd, seen);
            check($sformatf("v%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("v%0d_dividend", i), dvd, vecs[i].exp_dvd);
            check($sformatf("v%0d_div_valid_seen", i), 64'(seen), 64'(vecs[i].exp_lat != 1));
        end

        // Flush in BUSY cycle 30
        req_op = 2'b01; req_word = 1'b0; req_src1 = 64'd50; req_src2 = 64'd5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        check("fl_busy_before", 64'(div_valid), 64'd1);
        flush = 1'b1;
        #1;
        check("fl_div_valid_in_flush", 64'(div_valid), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        check("fl_div_valid_after", 64'(div_valid), 64'd0);
        hits = 0;
        repeat (80) begin
            if (resp_valid || div_valid) hits++;
            @(posedge clk); #1;
        end
        check("fl_no_resp", 64'(hits), 64'd0);
        run_op(2'b01, 1'b0, 64'd9, 64'd3, res, lat, dvd, seen);
        check("fl_next_result", res, 64'd3);
        check("fl_next_latency", 64'(lat), 64'd67);

        // Flush in IDLE blocks a simultaneous request
        req_op = 2'b01; req_src1 = 64'd123; req_src2 = 64'd4; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        check("fl_idle_div_valid", 64'(div_valid), 64'd0);
        check("fl_idle_dividend", div_dividend, 64'd9);
        check("fl_idle_req_ready", 64'(req_ready), 64'd1);

        // DONE held by backpressure, then back-to-back accept
        resp_ready = 1'b0;
        req_op = 2'b01; req_word = 1'b0; req_src1 = 64'd77; req_src2 = 64'd7; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        check("hold_latency", 64'(lat), 64'd67);
        req_src1 = 64'd81; req_src2 = 64'd9; req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("hold%0d_result", k), resp_result, 64'd11);
            check($sformatf("hold%0d_req_ready", k), 64'(req_ready), 64'd0);
            check($sformatf("hold%0d_resp_valid", k), 64'(resp_valid), 64'd1);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        #1;
        check("b2b_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b_div_valid", 64'(div_valid), 64'd1);
        check("b2b_resp_valid", 64'(resp_valid), 64'd0);
        check("b2b_dividend", div_dividend, 64'd81);
        lat = 1;
        while (!resp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        check("b2b_latency", 64'(lat), 64'd67);
        check("b2b_result", resp_result, 64'd9);
        @(posedge clk); #1;
        check("b2b_idle", 64'(resp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
